// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StFull,
    StStep,
    StHalted
  } fetch_state_t;

  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Opcode is the top nibble of an instruction of the given width (width <= 32).
  function automatic logic [3:0] opcode_of(input logic [31:0] instr, input int unsigned width);
    logic [31:0] sh;
    sh = instr >> (width - 4);
    return sh[3:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction FIFO holding {fetch address, instruction} pairs.
module fetch_fifo #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_data,
  input  logic [15:0]        push_pc,
  output logic               full,
  output logic               valid,
  input  logic               ready,
  output logic [INSTR_W-1:0] data,
  output logic [15:0]        pc
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [15:0]        pc_mem   [DEPTH];
  logic [AW:0]        wptr_q, rptr_q;
  logic               pop, wr_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign valid = (wptr_q != rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = valid && ready;
  // A push while full is accepted only when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign data  = data_mem[rptr_q[AW-1:0]];
  assign pc    = pc_mem[rptr_q[AW-1:0]];

  // Pointer update; pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wptr_q[AW-1:0]] <= push_data;
      pc_mem[wptr_q[AW-1:0]]   <= push_pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control: drives the program counter, reads instruction memory, decodes
// jump/halt, and queues fetched instructions for downstream decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 2,
  parameter logic [3:0]  OP_JMP  = fetch_pkg::OP_JMP,
  parameter logic [3:0]  OP_HLT  = fetch_pkg::OP_HLT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        pc,
  output logic               pc_start,
  output logic               pc_jump,
  output logic [7:0]         pc_jump_value,
  output logic               pc_halt,
  output logic               imem_req,
  output logic [15:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [15:0]        instr_pc,
  input  logic               instr_ready,
  output logic               halted
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] held_q;
  logic [15:0]        addr_q;
  logic [3:0]         rdata_op, held_op;
  logic               fifo_push, fifo_full, fifo_pop;
  logic [INSTR_W-1:0] push_data;

  assign rdata_op  = opcode_of(32'(imem_rdata), INSTR_W);
  assign held_op   = opcode_of(32'(held_q), INSTR_W);
  assign fifo_pop  = instr_valid && instr_ready;
  assign imem_addr = pc;
  assign halted    = (state_q == StHalted);

  // State register plus the fetch address and the word parked while the FIFO is full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      held_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StReq) addr_q <= pc;
      if (state_q == StWait && imem_rvalid) held_q <= imem_rdata;
    end
  end

  // Next state and PC/memory/FIFO controls.
  always_comb begin
    state_d       = state_q;
    pc_start      = 1'b0;
    pc_jump       = 1'b0;
    pc_jump_value = 8'h00;
    pc_halt       = 1'b1;
    imem_req      = 1'b0;
    fifo_push     = 1'b0;
    push_data     = imem_rdata;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_start = 1'b1;
          state_d  = StReq;
        end
      end
      StReq: begin
        imem_req = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (imem_rvalid) begin
          if (rdata_op == OP_JMP) begin
            pc_jump       = 1'b1;
            pc_jump_value = imem_rdata[7:0];
            pc_halt       = 1'b0;
            state_d       = StReq;
          end else if (fifo_full) begin
            state_d = StFull;
          end else begin
            fifo_push = 1'b1;
            state_d   = (rdata_op == OP_HLT) ? StHalted : StStep;
          end
        end
      end
      StFull: begin
        push_data = held_q;
        if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
          state_d   = (held_op == OP_HLT) ? StHalted : StStep;
        end
      end
      StStep: begin
        // The only non-jump cycle in which the PC may advance.
        pc_halt = 1'b0;
        state_d = StReq;
      end
      StHalted: begin
        if (start) begin
          pc_start = 1'b1;
          state_d  = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  fetch_fifo #(
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(push_data),
    .push_pc  (addr_q),
    .full     (fifo_full),
    .valid    (instr_valid),
    .ready    (instr_ready),
    .data     (instr_data),
    .pc       (instr_pc)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a PC model, memory responder and program model.
module tb_fetch_sequencer;

  typedef struct {
    logic [15:0] data;
    logic [15:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] tb_pc;
  logic        pc_start, pc_jump, pc_halt, imem_req, imem_rvalid;
  logic [7:0]  pc_jump_value;
  logic [15:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, halted;
  logic [15:0] instr_data, instr_pc;

  int checks = 0;
  int failures = 0;
  int jump_cnt = 0, start_cnt = 0, req_cnt = 0;
  logic [7:0] last_jump_val = 8'h00;
  logic prev_jump = 1'b0, prev_start = 1'b0;
  int lat_lo = 1, lat_hi = 1;
  int ready_mode = 1;

  logic [15:0] mem [256];
  exp_t        exp_q[$];
  logic [15:0] exp_addr[$];

  fetch_sequencer #(
    .INSTR_W(16),
    .DEPTH  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pc           (tb_pc),
    .pc_start     (pc_start),
    .pc_jump      (pc_jump),
    .pc_jump_value(pc_jump_value),
    .pc_halt      (pc_halt),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_rvalid  (imem_rvalid),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Program counter model: start reloads 0, jump loads the offset absolutely, else +1 when allowed.
  always @(posedge clk or posedge reset) begin
    if (reset)              tb_pc <= 16'h0;
    else if (pc_start)      tb_pc <= 16'h0;
    else if (pc_jump)       tb_pc <= {8'h00, pc_jump_value};
    else if (!pc_halt)      tb_pc <= tb_pc + 16'h1;
  end

  // Reference: execute the program image and list fetch addresses and delivered words.
  task automatic run_model();
    logic [15:0] p = 16'h0;
    logic [15:0] w;
    for (int n = 0; n < 400; n++) begin
      w = mem[p[7:0]];
      exp_addr.push_back(p);
      if (w[15:12] == 4'hE) begin
        p = {8'h00, w[7:0]};
      end else begin
        exp_q.push_back('{data: w, pc: p});
        if (w[15:12] == 4'hF) break;
        p = p + 16'h1;
      end
    end
  endtask

  // Memory responder: one outstanding read, latency lat_lo..lat_hi cycles.
  initial begin
    logic [15:0] a;
    int lat;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0;
    forever begin
      @(negedge clk);
      if (imem_req && !reset) begin
        a = imem_addr;
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req actual_addr=%0h expected=none", a);
        end else begin
          chk("imem_addr", 32'(a), 32'(exp_addr.pop_front()));
        end
        lat = $urandom_range(lat_hi, lat_lo);
        repeat (lat) @(posedge clk);
        #1;
        imem_rdata  = mem[a[7:0]];
        imem_rvalid = 1'b1;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0;
      end
    end
  end

  // Downstream ready: 0 = held low, 1 = held high, 2 = random per cycle.
  initial begin
    instr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       instr_ready = 1'b0;
        1:       instr_ready = 1'b1;
        default: instr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks PC-control protocol.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pc_jump) begin
          chk("jump_pc_halt", 32'(pc_halt), 0);
          chk("jump_start_excl", 32'(pc_start), 0);
          chk("jump_no_repeat", 32'(prev_jump), 0);
          jump_cnt++;
          last_jump_val = pc_jump_value;
        end
        if (pc_start) begin
          chk("start_pc_halt", 32'(pc_halt), 1);
          chk("start_no_repeat", 32'(prev_start), 0);
          start_cnt++;
        end
        if (imem_req) begin
          chk("req_not_halted", 32'(halted), 0);
          req_cnt++;
        end
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_instr actual data=%0h pc=%0h expected=none",
                     instr_data, instr_pc);
          end else begin
            e = exp_q.pop_front();
            chk("instr_data", 32'(instr_data), 32'(e.data));
            chk("instr_pc", 32'(instr_pc), 32'(e.pc));
          end
        end
        prev_jump  = pc_jump;
        prev_start = pc_start;
      end else begin
        prev_jump  = 1'b0;
        prev_start = 1'b0;
      end
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk("start_pulse", 32'(pc_start), 1);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (halted && exp_q.size() == 0 && exp_addr.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout actual halted=%0d pending=%0d expected halted=1 pending=0",
               name, halted, exp_q.size());
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  initial begin
    int snap, lows, a, t;
    reset = 1'b1;
    start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc_halt", 32'(pc_halt), 1);
    chk("rst_pc_start", 32'(pc_start), 0);
    chk("rst_pc_jump", 32'(pc_jump), 0);
    chk("rst_jump_value", 32'(pc_jump_value), 0);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Straight-line fetch, a jump over address 4, then halt and restart.
    mem[0] = 16'h1234; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hE005;
    mem[4] = 16'hBAD0; mem[5] = 16'h5555; mem[6] = 16'hF000;
    jump_cnt = 0; start_cnt = 0;
    run_model();
    do_start();
    wait_done("directed", 400);
    chk("jump_count", 32'(jump_cnt), 1);
    chk("jump_value", 32'(last_jump_val), 32'h05);
    chk("start_count", 32'(start_cnt), 1);
    snap = req_cnt;
    repeat (20) @(negedge clk);
    chk("halted_no_req", 32'(req_cnt), 32'(snap));
    chk("halted_flag", 32'(halted), 1);
    chk("halted_pc_halt", 32'(pc_halt), 1);
    run_model();
    do_start();
    wait_done("restart", 400);
    chk("restart_start_count", 32'(start_cnt), 2);

    // Backpressure: third word parks in the sequencer while the FIFO is full.
    clear_mem();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hF000;
    ready_mode = 0;
    snap = req_cnt;
    run_model();
    do_start();
    repeat (30) @(negedge clk);
    chk("full_req_count", 32'(req_cnt - snap), 3);
    chk("full_valid", 32'(instr_valid), 1);
    chk("full_pc", 32'(tb_pc), 2);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!pc_halt) lows++;
    end
    chk("full_pc_halt_held", 32'(lows), 0);
    ready_mode = 1;
    wait_done("backpressure", 400);

    // Asynchronous reset during an outstanding read.
    clear_mem();
    mem[0] = 16'h1234; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hF000;
    ready_mode = 0;
    lat_lo = 6; lat_hi = 6;
    snap = req_cnt;
    run_model();
    do_start();
    for (int i = 0; i < 60 && (req_cnt - snap) < 2; i++) @(negedge clk);
    chk("pre_reset_reqs", 32'(req_cnt - snap), 2);
    @(posedge clk);
    @(posedge clk);
    chk("pre_reset_valid", 32'(instr_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_pc_halt", 32'(pc_halt), 1);
    chk("arst_imem_req", 32'(imem_req), 0);
    chk("arst_instr_valid", 32'(instr_valid), 0);
    chk("arst_halted", 32'(halted), 0);
    chk("arst_pc_jump", 32'(pc_jump), 0);
    exp_q.delete();
    exp_addr.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ready_mode = 1;
    repeat (15) @(negedge clk);
    chk("post_reset_valid", 32'(instr_valid), 0);
    chk("post_reset_halted", 32'(halted), 0);

    // Randomized programs with jumps, variable latency and random ready.
    lat_lo = 1; lat_hi = 8;
    ready_mode = 2;
    for (int r = 0; r < 2; r++) begin
      clear_mem();
      a = 0;
      for (int k = 0; k < 50; k++) begin
        if (k > 0 && a < 180 && $urandom_range(0, 7) == 0) begin
          t = a + int'($urandom_range(2, 4));
          mem[a] = {8'hE0, 8'(t)};
          a = t;
        end
        mem[a] = {4'($urandom_range(0, 13)), 12'($urandom)};
        a++;
      end
      mem[a] = {4'hF, 12'($urandom)};
      run_model();
      do_start();
      wait_done("random", 3000);
    end

    repeat (5) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
